// File: rtl/counter_run_ctrl.sv
// Run scheduler for D-flip-flop counters: load, step to end value, repeat.
// Start/busy/done host handshake; live count with valid strobe downstream.
module counter_run_ctrl #(
    parameter int WIDTH    = 3,
    parameter int REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    cfg_start,
    input  logic [WIDTH-1:0]    cfg_end,
    input  logic                cfg_dir,
    input  logic [REPEAT_W-1:0] cfg_repeat,
    input  logic                abort,
    output logic                busy,
    output logic [WIDTH-1:0]    count,
    output logic                count_valid,
    output logic [REPEAT_W-1:0] run_idx,
    output logic                wrap,
    output logic                done,
    output logic                aborted
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [WIDTH-1:0]    ONE_C = WIDTH'(1);
    localparam logic [REPEAT_W-1:0] ONE_R = REPEAT_W'(1);

    logic [1:0]          r_state;
    logic [WIDTH-1:0]    r_cfg_start;
    logic [WIDTH-1:0]    r_cfg_end;
    logic                r_cfg_dir;
    logic [REPEAT_W-1:0] r_cfg_repeat;

    logic                r_busy;
    logic [WIDTH-1:0]    r_count;
    logic                r_count_valid;
    logic [REPEAT_W-1:0] r_run_idx;
    logic                r_wrap;
    logic                r_done;
    logic                r_aborted;

    logic [WIDTH-1:0]    w_step;
    logic                w_at_end;
    logic                w_last_pass;

    // Stepping wraps modulo 2^WIDTH in either direction.
    assign w_step      = r_cfg_dir ? (r_count - ONE_C) : (r_count + ONE_C);
    assign w_at_end    = (r_count == r_cfg_end);
    assign w_last_pass = (r_run_idx == r_cfg_repeat);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cfg_start   <= '0;
            r_cfg_end     <= '0;
            r_cfg_dir     <= 1'b0;
            r_cfg_repeat  <= '0;
            r_busy        <= 1'b0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_run_idx     <= '0;
            r_wrap        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_wrap    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_cfg_start  <= cfg_start;
                        r_cfg_end    <= cfg_end;
                        r_cfg_dir    <= cfg_dir;
                        r_cfg_repeat <= cfg_repeat;
                        r_busy       <= 1'b1;
                        r_state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else begin
                        r_count       <= r_cfg_start;
                        r_run_idx     <= '0;
                        r_count_valid <= 1'b1;
                        r_state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Abort wins over terminal detection.
                    if (abort) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_count_valid <= 1'b0;
                        r_aborted     <= 1'b1;
                    end else if (!w_at_end) begin
                        r_count <= w_step;
                    end else if (!w_last_pass) begin
                        r_count   <= r_cfg_start;
                        r_run_idx <= r_run_idx + ONE_R;
                        r_wrap    <= 1'b1;
                    end else begin
                        r_state       <= ST_DONE;
                        r_count_valid <= 1'b0;
                        r_done        <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_busy        <= 1'b0;
                    r_count_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign count       = r_count;
    assign count_valid = r_count_valid;
    assign run_idx     = r_run_idx;
    assign wrap        = r_wrap;
    assign done        = r_done;
    assign aborted     = r_aborted;

endmodule

// File: doc/counter_run_ctrl.md
# counter_run_ctrl

Sequencer for the team's D-flip-flop counters: loads a programmable start value, steps the count up or down to a programmable end value, then repeats the pass a programmable number of times. Start/busy/done handshake toward a host controller. Presents the live count with a valid strobe to the downstream datapath. Sits between control logic and any counter-driven datapath (time-slot stepping, address sweeps) as the run scheduler.

## Interface
Parameters:
- WIDTH, 3, count width; arithmetic is modulo 2^WIDTH
- REPEAT_W, 4, width of the repeat field

Ports:
- clk  in  1  single clock; everything updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- cfg_start  in  WIDTH  first count value of each pass
- cfg_end  in  WIDTH  last count value of each pass
- cfg_dir  in  1  0 = count up, 1 = count down
- cfg_repeat  in  REPEAT_W  extra passes; total passes = cfg_repeat+1
- abort  in  1  terminate the current run
- busy  out  1  high whenever state != IDLE
- count  out  WIDTH  current count
- count_valid  out  1  count is a live step of the run
- run_idx  out  REPEAT_W  index of the current pass, 0..cfg_repeat
- wrap  out  1  1-cycle pulse in the first cycle of passes 1..cfg_repeat
- done  out  1  1-cycle pulse on normal completion
- aborted  out  1  1-cycle pulse on abort

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered.
- **IDLE**
  - start=1 and abort=0: latch all cfg_* into shadow registers, go to LOAD.
  - cfg_* changes after that latch have no effect on the run.
- **LOAD**
  - count <= S, run_idx <= 0, go to RUN.
- **RUN** (count_valid=1)
  - count != E: count <= count+1 (up) or count-1 (down), modulo 2^WIDTH. Wrap-around through 2^WIDTH-1/0 is legal.
  - count == E and run_idx < R: count <= S, run_idx+1, wrap=1 next cycle.
  - count == E and run_idx == R: go to DONE.
- **DONE**
  - done=1, count_valid=0, busy=1, count holds E. Next edge goes to IDLE.
- **abort**
  - abort=1 in LOAD or RUN: next state IDLE, aborted=1 for 1 cycle, count holds, done is not asserted.
  - abort has priority over terminal detection.
  - abort in IDLE or DONE is ignored.
- **start**
  - start is ignored in LOAD, RUN and DONE; it is not queued.
  - start and abort both high in IDLE: start is ignored.
- **Pass length**
  - Up: L = ((E-S) mod 2^WIDTH)+1.
  - Down: L = ((S-E) mod 2^WIDTH)+1.
  - S==E gives L=1.
- **reset**
  - Reset in any state, including mid-run: state IDLE.
  - count=0, run_idx=0, and busy, count_valid, wrap, done, aborted all 0.
  - Shadow configuration registers are cleared to 0.

## Timing
- start sampled at edge k: busy=1 and LOAD state from k.
- First valid count (=S) appears after edge k+1.
- count_valid is high for exactly (R+1)*L consecutive cycles.
- done is high for the single cycle after the last valid count. busy drops one cycle later.
- Total busy = (R+1)*L + 2 cycles.
- Back-to-back runs: earliest next start is sampled in the cycle busy=0, giving 1 idle cycle minimum between runs.
- wrap coincides with the count_valid cycle carrying S for passes 1..R.
- Abort latency: 1 edge.

## Test plan
- Reset: assert reset for 2 cycles mid-RUN -> count=0, busy=0, count_valid=0, done=0, run_idx=0; a new start afterward runs normally.
- S=2, E=5, up, R=0 -> valid counts 2,3,4,5; done pulse the next cycle; busy high 6 cycles; wrap never asserted.
- Up wrap-around, S=6, E=1, R=0 -> counts 6,7,0,1; done after 1.
- Down repeat, S=1, E=6, dir=1, R=1 -> counts 1,0,7,6,1,0,7,6; wrap=1 on the second "1"; run_idx 0 for 4 cycles then 1; single done.
- S=E=3, R=2 -> counts 3,3,3 with wrap on cycles 2 and 3; run_idx 0,1,2; busy 5 cycles.
- Abort and ignored starts: start S=0, E=7, up. Pulse start again at count=2 -> ignored. Pulse abort at count=4 -> next cycle IDLE, aborted=1, count=4 held, no done. Start asserted in the DONE cycle of a normal run -> ignored.
